// File: rtl/scheduler_nport.sv
// ---------------------------------------------------------------------------
// scheduler_nport
//
// Shares one BRAM bank among NUM_PORTS requesters. Each cycle one in-range
// requester is picked and its access is driven to the BRAM on the next edge.
// Read results return on rvalid_o after MEM_LATENCY cycles. A small tag
// pipeline follows each read so that the data reaches the right port.
//
// Optional feature macro: SCHED_RR_EN
//   defined   -> round-robin arbitration with a rotating search pointer
//   undefined -> fixed priority, port 0 highest
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_i        per-port request, held until granted
//   we_i         per-port write enable (qualified by req_i)
//   addr_i       packed per-port addresses, port 0 in LSBs
//   wdata_i      packed per-port write data, port 0 in LSBs
//   gnt_o        registered one-hot grant pulse
//   stall_o      registered: port was eligible last cycle and lost
//   rvalid_o     one-hot read-data-valid pulse
//   rdata_o      read data shared by all ports (mem_rdata_i passed through)
//   mem_en_o     registered BRAM enable
//   mem_we_o     registered BRAM write enable
//   mem_addr_o   registered absolute BRAM address
//   mem_wdata_o  registered BRAM write data
//   mem_rdata_i  BRAM read data, valid MEM_LATENCY cycles after a read
// ---------------------------------------------------------------------------
module scheduler_nport #(
    parameter int NUM_PORTS   = 4,
    parameter int ADDR_WIDTH  = 13,
    parameter int DATA_WIDTH  = 32,
    parameter int LOWER_ADDR  = 0,
    parameter int UPPER_ADDR  = 4,
    parameter int MEM_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PORTS-1:0]             req_i,
    input  logic [NUM_PORTS-1:0]             we_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wdata_i,
    output logic [NUM_PORTS-1:0]             gnt_o,
    output logic [NUM_PORTS-1:0]             stall_o,
    output logic [NUM_PORTS-1:0]             rvalid_o,
    output logic [DATA_WIDTH-1:0]            rdata_o,
    output logic                             mem_en_o,
    output logic                             mem_we_o,
    output logic [ADDR_WIDTH-1:0]            mem_addr_o,
    output logic [DATA_WIDTH-1:0]            mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]            mem_rdata_i
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    // The range test is done as one unsigned compare on the offset from
    // LOWER_ADDR: addresses below LOWER_ADDR wrap to large values and fail.
    localparam logic [ADDR_WIDTH-1:0] LO_A = ADDR_WIDTH'(LOWER_ADDR);
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(UPPER_ADDR - LOWER_ADDR);

    logic [NUM_PORTS-1:0]  eligible;
    logic                  winnerValid;
    logic [IDX_W-1:0]      winnerIdx;
    logic [ADDR_WIDTH-1:0] winAddr;
    logic [DATA_WIDTH-1:0] winData;
    logic                  winWe;
    logic [NUM_PORTS-1:0]  gnt_d;
    logic [NUM_PORTS-1:0]  stall_d;

    logic [NUM_PORTS-1:0]  gnt_q;
    logic [NUM_PORTS-1:0]  stall_q;
    logic                  mem_en_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [IDX_W-1:0]      issueIdx_q;
    logic [MEM_LATENCY-1:0] tagValid_q;
    logic [IDX_W-1:0]      tagIdx_q [MEM_LATENCY];

`ifdef SCHED_RR_EN
    logic [IDX_W-1:0]      rrPtr_q;
    logic [IDX_W-1:0]      rrPtr_d;
`endif

    // Eligibility per port: request present and address inside the bank.
    always_comb begin
        logic [ADDR_WIDTH-1:0] offset;
        offset   = '0;
        eligible = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            offset      = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] - LO_A;
            eligible[i] = req_i[i] && (offset <= SPAN);
        end
    end

    // Winner selection. Loops run from the lowest priority candidate up so
    // the last hit (the highest priority) is the one that sticks.
    always_comb begin
        winnerValid = 1'b0;
        winnerIdx   = '0;
`ifdef SCHED_RR_EN
        begin
            int cand;
            cand = 0;
            for (int k = NUM_PORTS - 1; k >= 0; k--) begin
                cand = int'(rrPtr_q) + k;
                if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
                if (eligible[cand[IDX_W-1:0]]) begin
                    winnerValid = 1'b1;
                    winnerIdx   = IDX_W'(cand);
                end
            end
        end
        rrPtr_d = rrPtr_q;
        if (winnerValid) begin
            rrPtr_d = (winnerIdx == IDX_W'(NUM_PORTS - 1)) ? '0 : winnerIdx + IDX_W'(1);
        end
`else
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winnerValid = 1'b1;
                winnerIdx   = IDX_W'(i);
            end
        end
`endif
    end

    // Route the winner's access fields and form the grant/stall vectors.
    always_comb begin
        winAddr = '0;
        winData = '0;
        winWe   = 1'b0;
        gnt_d   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (IDX_W'(i) == winnerIdx) begin
                winAddr = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                winData = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                winWe   = we_i[i];
            end
        end
        if (winnerValid) gnt_d[winnerIdx] = 1'b1;
        stall_d = eligible & ~gnt_d;
    end

    // Registered grant, stall and BRAM command. Address and write data only
    // move on a grant so they hold through idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q       <= '0;
            stall_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            issueIdx_q  <= '0;
        end else begin
            gnt_q    <= gnt_d;
            stall_q  <= stall_d;
            mem_en_q <= winnerValid;
            mem_we_q <= winnerValid & winWe;
            if (winnerValid) begin
                mem_addr_q  <= winAddr;
                mem_wdata_q <= winData;
                issueIdx_q  <= winnerIdx;
            end
        end
    end

    // Read tag pipeline: stage 0 is loaded from the cycle the read is on the
    // BRAM pins, so the last stage lines up with the BRAM data. Reset empties
    // it, which discards any read still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tagValid_q <= '0;
            for (int s = 0; s < MEM_LATENCY; s++) tagIdx_q[s] <= '0;
        end else begin
            tagValid_q[0] <= mem_en_q & ~mem_we_q;
            tagIdx_q[0]   <= issueIdx_q;
            for (int s = 1; s < MEM_LATENCY; s++) begin
                tagValid_q[s] <= tagValid_q[s-1];
                tagIdx_q[s]   <= tagIdx_q[s-1];
            end
        end
    end

`ifdef SCHED_RR_EN
    // Round-robin search pointer; it only moves on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rrPtr_q <= '0;
        else        rrPtr_q <= rrPtr_d;
    end
`endif

    // Decode the returning tag into a one-hot valid.
    always_comb begin
        rvalid_o = '0;
        if (tagValid_q[MEM_LATENCY-1]) rvalid_o[tagIdx_q[MEM_LATENCY-1]] = 1'b1;
    end

    assign rdata_o     = mem_rdata_i;
    assign gnt_o       = gnt_q;
    assign stall_o     = stall_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_scheduler_nport.sv
// ---------------------------------------------------------------------------
// tb_scheduler_nport
//
// Drives scheduler_nport with directed scenarios followed by random traffic
// and compares every output each cycle with a transaction-level model of
// the scheduler. A simple BRAM stand-in answers the DUT's memory port.
// ---------------------------------------------------------------------------
module tb_scheduler_nport;

    localparam int N     = 4;
    localparam int AW    = 13;
    localparam int DW    = 32;
    localparam int LOWER = 0;
    localparam int UPPER = 4;
    localparam int LAT   = 2;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    stall;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic            memEn;
    logic            memWe;
    logic [AW-1:0]   memAddr;
    logic [DW-1:0]   memWdata;
    logic [DW-1:0]   memRdata;

    scheduler_nport #(
        .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .LOWER_ADDR(LOWER), .UPPER_ADDR(UPPER), .MEM_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .gnt_o(gnt), .stall_o(stall), .rvalid_o(rvalid), .rdata_o(rdata),
        .mem_en_o(memEn), .mem_we_o(memWe), .mem_addr_o(memAddr),
        .mem_wdata_o(memWdata), .mem_rdata_i(memRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM stand-in with LAT cycles of read latency.
    logic [DW-1:0] benchMem [32];
    logic [DW-1:0] rdPipe [LAT];

    always @(posedge clk) begin
        if (memEn && memWe)  benchMem[memAddr[4:0]] <= memWdata;
        if (memEn && !memWe) rdPipe[0] <= benchMem[memAddr[4:0]];
        for (int s = 1; s < LAT; s++) rdPipe[s] <= rdPipe[s-1];
    end
    assign memRdata = rdPipe[LAT-1];

    // Reference model state.
    typedef struct {
        int            due;
        int            port;
        logic [DW-1:0] data;
    } rdExp_t;

    rdExp_t        rdQueue [$];
    logic [DW-1:0] refMem [32];
    int            cycleCount;
`ifdef SCHED_RR_EN
    int            refPtr;
`endif

    logic [N-1:0]  expGnt, expStall, expRvalid;
    logic          expMemEn, expMemWe;
    logic [AW-1:0] expMemAddr;
    logic [DW-1:0] expMemWdata, expRdata;

    int            stimAddr [N];
    logic [DW-1:0] stimData [N];

    int totalChecks;
    int passedChecks;
    int failedChecks;

    // Single comparison point.
    task automatic checkValue(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
        totalChecks++;
        assert (observed === expected) begin
            passedChecks++;
        end else begin
            failedChecks++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)",
                   tag, observed, expected, cycleCount);
        end
    endtask

    // Compare every DUT output with the model's expectation for this cycle.
    task automatic checkOutput();
        checkValue("gnt",       64'(gnt),      64'(expGnt));
        checkValue("stall",     64'(stall),    64'(expStall));
        checkValue("mem_en",    64'(memEn),    64'(expMemEn));
        checkValue("mem_we",    64'(memWe),    64'(expMemWe));
        checkValue("mem_addr",  64'(memAddr),  64'(expMemAddr));
        checkValue("mem_wdata", 64'(memWdata), 64'(expMemWdata));
        checkValue("rvalid",    64'(rvalid),   64'(expRvalid));
        if (expRvalid != '0) checkValue("rdata", 64'(rdata), 64'(expRdata));
    endtask

    // Model reset: everything observable returns to zero, reads in flight
    // are forgotten, memory contents survive.
    task automatic modelReset();
        rdQueue.delete();
`ifdef SCHED_RR_EN
        refPtr = 0;
`endif
        expGnt = '0; expStall = '0; expRvalid = '0;
        expMemEn = 1'b0; expMemWe = 1'b0;
        expMemAddr = '0; expMemWdata = '0; expRdata = '0;
    endtask

    // Drive one cycle of requests, predict the result, clock, then check.
    task automatic applyStimulus(input logic [N-1:0] reqV, input logic [N-1:0] weV);
        logic [N-1:0] elig;
        int win;
        for (int i = 0; i < N; i++) begin
            addr[i*AW +: AW]  = AW'(stimAddr[i]);
            wdata[i*DW +: DW] = stimData[i];
        end
        req = reqV;
        we  = weV;

        for (int i = 0; i < N; i++)
            elig[i] = reqV[i] && (stimAddr[i] >= LOWER) && (stimAddr[i] <= UPPER);
        win = -1;
`ifdef SCHED_RR_EN
        for (int k = 0; k < N; k++)
            if (win < 0 && elig[(refPtr + k) % N]) win = (refPtr + k) % N;
`else
        for (int i = 0; i < N; i++)
            if (win < 0 && elig[i]) win = i;
`endif
        expGnt   = '0;
        expStall = elig;
        expMemEn = 1'b0;
        expMemWe = 1'b0;
        if (win >= 0) begin
            expGnt[win]   = 1'b1;
            expStall[win] = 1'b0;
            expMemEn      = 1'b1;
            expMemWe      = weV[win];
            expMemAddr    = AW'(stimAddr[win]);
            expMemWdata   = stimData[win];
            if (weV[win]) refMem[stimAddr[win]] = stimData[win];
            else rdQueue.push_back('{due: cycleCount + 1 + LAT, port: win,
                                     data: refMem[stimAddr[win]]});
`ifdef SCHED_RR_EN
            refPtr = (win + 1) % N;
`endif
        end

        @(posedge clk);
        cycleCount++;
        #1;
        expRvalid = '0;
        if (rdQueue.size() > 0 && rdQueue[0].due == cycleCount) begin
            expRvalid[rdQueue[0].port] = 1'b1;
            expRdata = rdQueue[0].data;
            void'(rdQueue.pop_front());
        end
        checkOutput();
    endtask

    task automatic setPort(input int p, input int a, input logic [DW-1:0] d);
        stimAddr[p] = a;
        stimData[p] = d;
    endtask

    task automatic idleCycles(input int n);
        for (int c = 0; c < n; c++) applyStimulus('0, '0);
    endtask

    initial begin
        totalChecks = 0; passedChecks = 0; failedChecks = 0; cycleCount = 0;
        for (int i = 0; i < 32; i++) begin
            benchMem[i] = 32'hA000_0000 + i;
            refMem[i]   = 32'hA000_0000 + i;
        end
        for (int s = 0; s < LAT; s++) rdPipe[s] = '0;
        for (int i = 0; i < N; i++) setPort(i, 0, '0);
        req = '0; we = '0; addr = '0; wdata = '0;

        // Reset state.
        rst_n = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        cycleCount += 2;
        #1;
        checkOutput();
        rst_n = 1'b1;
        $display("[TB] reset released");

        // Single read from port 2 at address 3, on the first edge after reset.
        setPort(2, 3, 32'h0);
        applyStimulus(4'b0100, 4'b0000);
        idleCycles(LAT + 1);

        // Out-of-range write from port 1.
        setPort(1, 5, 32'hDEAD_BEEF);
        applyStimulus(4'b0010, 4'b0010);
        idleCycles(1);

        // Fill the bank with known data, one write per cycle.
        for (int a = LOWER; a <= UPPER; a++) begin
            setPort(a % N, a, 32'h5500_0000 + a * 32'h11);
            applyStimulus(N'(1 << (a % N)), N'(1 << (a % N)));
        end

        // Contention: ports 0, 1, 3 reading for three cycles.
        setPort(0, 1, '0); setPort(1, 2, '0); setPort(3, 4, '0);
        repeat (3) applyStimulus(4'b1011, 4'b0000);
        idleCycles(LAT + 1);

        // Back-to-back reads from port 3 then port 0.
        setPort(3, 0, '0);
        applyStimulus(4'b1000, 4'b0000);
        setPort(0, 2, '0);
        applyStimulus(4'b0001, 4'b0000);
        idleCycles(LAT + 1);

        // Pointer wrap: a grant to port 2 leaves the RR pointer at 3.
        setPort(2, 1, '0);
        applyStimulus(4'b0100, 4'b0000);
        setPort(3, 3, '0); setPort(0, 4, '0);
        repeat (2) applyStimulus(4'b1001, 4'b0000);
        idleCycles(LAT + 1);

        // Reset between a read grant and its return.
        setPort(1, 2, '0);
        applyStimulus(4'b0010, 4'b0000);
        req = '0;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput();
        @(posedge clk);
        cycleCount++;
        #1;
        checkOutput();
        rst_n = 1'b1;
        idleCycles(LAT + 2);
        setPort(3, 1, '0); setPort(1, 3, '0);
        applyStimulus(4'b1010, 4'b0000);
        idleCycles(LAT + 1);

        // Random traffic, occasionally outside the bank.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                int r;
                r = int'($urandom_range(0, 9));
                setPort(i, (r < 8) ? r : int'($urandom_range(0, 8191)), $urandom);
            end
            applyStimulus(N'($urandom), N'($urandom));
        end
        idleCycles(LAT + 2);

        if (failedChecks != 0) $display("[TB] see error messages above");
        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
